// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of the downstream
// a00/a01/a1X select tree. One source owns the output path at a time for a
// bounded burst of handshaked beats; one IDLE bubble separates grants.
module mux_sel_arbiter #(
    parameter int MAX_BEATS = 4,   // beats per grant, 0 = unlimited
    parameter int CNT_W     = 8    // beat counter width, MAX_BEATS < 2**CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req,
    input  logic             out_ready,
    output logic [2:0]       gnt,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit               LIMITED = (MAX_BEATS != 0);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    state_t           state, state_nxt;
    logic [1:0]       last_ptr, last_ptr_nxt;
    logic [2:0]       gnt_nxt;
    logic [1:0]       sel_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       pick;
    logic             accept;
    logic             release_now;

    // First requesting source after lp, scanning lp+1, lp+2, lp+3 (mod 3).
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] lp);
        logic [1:0] c0, c1, c2;
        case (lp)
            2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
            default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
        endcase
        if (r[c0])      return c0;
        else if (r[c1]) return c1;
        else            return c2;
    endfunction

    // gnt is zero in IDLE, so out_valid cannot assert there.
    assign out_valid = |(gnt & req);
    assign accept    = out_valid & out_ready;
    assign cnt_inc   = beat_cnt + 1'b1;
    assign busy      = (state == BUSY);
    assign pick      = rr_pick(req, last_ptr);

    // Release when the owner drops its request or the accepted beat completes the burst.
    assign release_now = !out_valid || (LIMITED && accept && (cnt_inc == MAX_CNT));

    // Next-state, grant, select and beat-count decisions.
    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        sel_nxt      = sel;
        cnt_nxt      = beat_cnt;
        last_ptr_nxt = last_ptr;
        case (state)
            IDLE: begin
                gnt_nxt = 3'b000;
                if (|req) begin
                    state_nxt = BUSY;
                    gnt_nxt   = 3'b001 << pick;
                    sel_nxt   = pick;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_nxt    = IDLE;
                    gnt_nxt      = 3'b000;
                    cnt_nxt      = '0;
                    last_ptr_nxt = sel;  // sel encodes the granted index
                end else if (accept && (beat_cnt != '1)) begin
                    cnt_nxt = cnt_inc;   // saturates at all-ones in unlimited mode
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 3'b000;
            end
        endcase
    end

    // State and registered outputs; reset takes effect without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 3'b000;
            sel      <= 2'b00;
            beat_cnt <= '0;
            last_ptr <= 2'd2;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            sel      <= sel_nxt;
            beat_cnt <= cnt_nxt;
            last_ptr <= last_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: a limited-burst instance (MAX_BEATS=4) and an
// unlimited instance (MAX_BEATS=0, 3-bit counter) share the same stimulus and
// are compared every cycle against a grant/ownership model.
module tb_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic       out_ready;

    logic [2:0] gnt_a, gnt_b;
    logic [1:0] sel_a, sel_b;
    logic       ov_a, ov_b;
    logic [7:0] cnt_a;
    logic [2:0] cnt_b;
    logic       busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    // Model state per instance: owner index (-1 when idle), last owner, beats, select.
    int m_own  [2];
    int m_last [2];
    int m_cnt  [2];
    int m_sel  [2];
    int m_max  [2] = '{4, 0};
    int m_cmax [2] = '{255, 7};

    always #5 clk = ~clk;

    mux_sel_arbiter #(.MAX_BEATS(4), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .gnt(gnt_a), .sel(sel_a), .out_valid(ov_a), .beat_cnt(cnt_a), .busy(busy_a)
    );

    mux_sel_arbiter #(.MAX_BEATS(0), .CNT_W(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .gnt(gnt_b), .sel(sel_b), .out_valid(ov_b), .beat_cnt(cnt_b), .busy(busy_b)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_own[d]  = -1;
            m_last[d] = 2;
            m_cnt[d]  = 0;
            m_sel[d]  = 0;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            int eg, ev;
            eg = (m_own[d] < 0) ? 0 : (1 << m_own[d]);
            ev = (m_own[d] >= 0 && req[m_own[d]] == 1'b1) ? 1 : 0;
            check_val($sformatf("gnt%0d", d), (d == 0) ? 32'(gnt_a) : 32'(gnt_b), eg);
            check_val($sformatf("sel%0d", d), (d == 0) ? 32'(sel_a) : 32'(sel_b), m_sel[d]);
            check_val($sformatf("busy%0d", d), (d == 0) ? 32'(busy_a) : 32'(busy_b), (m_own[d] >= 0) ? 1 : 0);
            check_val($sformatf("out_valid%0d", d), (d == 0) ? 32'(ov_a) : 32'(ov_b), ev);
            check_val($sformatf("beat_cnt%0d", d), (d == 0) ? 32'(cnt_a) : 32'(cnt_b), m_cnt[d]);
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (m_own[d] < 0) begin
                bit found = 0;
                for (int k = 1; k <= 3; k++) begin
                    int idx;
                    idx = (m_last[d] + k) % 3;
                    if (!found && req[idx]) begin
                        found    = 1;
                        m_own[d] = idx;
                        m_sel[d] = idx;
                        m_cnt[d] = 0;
                    end
                end
            end else begin
                int  n;
                bit  acc;
                acc = req[m_own[d]] && out_ready;
                n   = m_cnt[d] + (acc ? 1 : 0);
                if (!req[m_own[d]] || (m_max[d] != 0 && acc && n == m_max[d])) begin
                    m_last[d] = m_own[d];
                    m_own[d]  = -1;
                    m_cnt[d]  = 0;
                end else begin
                    m_cnt[d] = (n > m_cmax[d]) ? m_cmax[d] : n;
                end
            end
        end
    endtask

    task automatic cycle(input logic [2:0] r, input logic rd);
        req       = r;
        out_ready = rd;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Assert reset between edges and check that outputs clear before any clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] r;
        rst_n     = 1'b0;
        req       = 3'b000;
        out_ready = 1'b0;
        model_reset();
        #4;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester, full burst, then bubble with sel held.
        for (int i = 0; i < 7; i++) cycle(3'b001, 1'b1);
        for (int i = 0; i < 2; i++) cycle(3'b000, 1'b1);

        // All requesting: rotation on the limited instance, saturation on the unlimited one.
        for (int i = 0; i < 16; i++) cycle(3'b111, 1'b1);
        for (int i = 0; i < 2; i++) cycle(3'b000, 1'b0);

        // Source 1 stalled by out_ready, then resumes.
        for (int i = 0; i < 4; i++) cycle(3'b010, 1'b0);
        for (int i = 0; i < 5; i++) cycle(3'b010, 1'b1);
        cycle(3'b000, 1'b0);

        // Source 2 drops after one beat with source 0 pending.
        cycle(3'b100, 1'b1);
        cycle(3'b101, 1'b1);
        cycle(3'b001, 1'b1);
        for (int i = 0; i < 3; i++) cycle(3'b001, 1'b1);

        // Fourth beat coincides with the request drop.
        for (int i = 0; i < 3; i++) cycle(3'b000, 1'b0);
        for (int i = 0; i < 4; i++) cycle(3'b011, 1'b1);
        cycle(3'b010, 1'b1);
        for (int i = 0; i < 3; i++) cycle(3'b011, 1'b1);

        // Reset mid-burst, then arbitration restarts at source 0.
        for (int i = 0; i < 3; i++) cycle(3'b000, 1'b0);
        for (int i = 0; i < 4; i++) cycle(3'b010, 1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(3'b011, 1'b1);

        // Randomized traffic with sticky requests and occasional resets.
        r = 3'b000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
            cycle(r, ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
